alu_result_monitor: RTL
=======================

Name: alu_result_monitor

Overview:
- Receiving end of the CPU result interface: samples `alu_result`, `NegativeFlag` and `ZeroFlag` on qualified cycles.
- Checks flag consistency against the sampled result and buffers each sample in a FIFO.
- Buffered entries drain to a downstream consumer (trace port, scoreboard or debug bus) over a valid/ready handshake.
- Sits beside the CPU and attaches to the same output wires the CPU bench watches.

Parameters:
- DATA_W, 32, width of `alu_result` and `out_data`.
- DEPTH, 8, FIFO entries; power of two, at least 2.
- ERR_W, 16, width of the saturating flag-error counter.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset; sampled on clk rising edge
- in_valid  in  1  current result/flags are meaningful this cycle
- alu_result  in  DATA_W  CPU ALU result
- NegativeFlag  in  1  CPU negative flag
- ZeroFlag  in  1  CPU zero flag
- out_ready  in  1  consumer accepts head entry
- clr_status  in  1  single-cycle pulse; clears `overflow` and `err_count`
- out_valid  out  1  FIFO non-empty; head entry presented
- out_data  out  DATA_W  head entry result
- out_neg  out  1  head entry NegativeFlag
- out_zero  out  1  head entry ZeroFlag
- out_flag_err  out  1  head entry failed the flag check
- count  out  log2(DEPTH)+1  occupancy
- full  out  1  count == DEPTH
- overflow  out  1  sticky: a sample was dropped
- err_count  out  ERR_W  saturating count of flag mismatches

Behaviour:
- Reset (`reset`=0 at a clk edge): FIFO pointers and count go to 0. All outputs reset to 0: `out_valid`, `count`, `full`, `overflow`, `err_count`, `out_data`, `out_neg`, `out_zero`, `out_flag_err`. FIFO contents are don't-care.
- Reset mid-operation discards all buffered entries. No pop is signalled.
- Flag check is combinational on the input:
  - expected_z = (alu_result == 0)
  - expected_n = alu_result[DATA_W-1]
  - err = (ZeroFlag != expected_z) | (NegativeFlag != expected_n)
- Push: a qualified sample writes {alu_result, NegativeFlag, ZeroFlag, err} at the tail pointer.
  - The push is accepted when `full`=0, or when a pop occurs in the same cycle (full with simultaneous pop: count stays DEPTH).
- Drop: a qualified sample arriving when full with no pop is dropped. `overflow` is set the next cycle and holds until `clr_status` or reset.
- err_count: increments on every qualified sample with err=1, including dropped samples. It saturates at all-ones and never wraps.
- Pop: occurs when `out_valid` and `out_ready` are both 1 at a clk edge.
  - `out_*` present the head entry (first-word fall-through).
  - The next entry appears on the cycle after the pop.
- Latency: a push into an empty FIFO raises `out_valid` one cycle later. Push and pop on the same cycle while empty is impossible, because `out_valid`=0.
- Pointers wrap modulo DEPTH. `count` updates as +1 (push only), -1 (pop only), or unchanged (both or neither).
- `out_data`/flags are stable while `out_valid`=1 and `out_ready`=0.
- clr_status and events in the same cycle:
  - clr_status with a simultaneous drop: `overflow` ends at 1 (the event wins).
  - clr_status with a simultaneous error: `err_count` ends at 1.
- Status FSM with two states, NORMAL and OVERFLOWED:
  - NORMAL to OVERFLOWED on a drop.
  - OVERFLOWED to NORMAL on `clr_status` without a simultaneous drop.
  - `overflow` = (state == OVERFLOWED).

Optional Feature:
- Macro: MON_CHANGE_ONLY_EN.
- When defined:
  - A sample is qualified only if `in_valid`=1 and {alu_result, NegativeFlag, ZeroFlag} differs from the last qualified sample.
  - The first `in_valid` after reset is always qualified.
  - The comparison register updates even when the sample is dropped.
- When undefined: every `in_valid`=1 cycle is qualified and no comparison register exists.

Decomposition:
- Package `alu_mon_pkg`:
  - DATA_W and ERR_W defaults
  - entry width (DATA_W+3)
  - entry field bit offsets (ERR, ZERO, NEG, DATA)
  - status FSM state encoding
- Sub-module `mon_fifo`:
  - generic synchronous FWFT FIFO with parameters WIDTH and DEPTH
  - ports: push, pop, din, dout, count, full, empty
- The top level holds the flag checker, qualification/change logic, drop/overflow FSM and err counter.

Test Plan:
- Reset: hold `reset`=0 for 2 cycles with `in_valid`=1, then release. Required: all outputs 0 during and one cycle after release; the first push appears on cycle 2.
- Consistent flags: push 32'h0000_0000/N0/Z1, then 32'h8000_0001/N1/Z0, with `out_ready`=1. Required: two pops in order, `out_flag_err`=0, `err_count`=0.
- Inconsistent flags: push 32'h0000_0005/N0/Z1. Required: popped entry has `out_flag_err`=1 and `err_count`=1. Force 65537 such samples: `err_count` sticks at 16'hFFFF.
- Fill and drop (DEPTH=8, `out_ready`=0): push 9 samples. Required: `full`=1, `count`=8, `overflow`=1. Drain yields the first 8 values in order. Pulse `clr_status`: `overflow`=0.
- Full with simultaneous push and pop: FIFO full, push 32'hA5A5_A5A5 while `out_ready`=1. Required: no drop, `count` stays 8, the new value is the last entry drained.
- With MON_CHANGE_ONLY_EN: hold 32'h0000_0003 for 5 cycles, then 32'h0000_0004. Required: exactly 2 entries captured. Without the macro: 6 entries captured.

Source files
------------

// File: rtl/alu_mon_pkg.sv
// Shared definitions for the ALU result monitor: default widths, the layout
// of a buffered FIFO entry and the encoding of the overflow status FSM.
package alu_mon_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ERR_W_DEF  = 16;

    // An entry is {result, negative flag, zero flag, flag-check error}
    localparam int FLAG_BITS   = 3;
    localparam int ENTRY_W_DEF = DATA_W_DEF + FLAG_BITS;

    // Bit offsets of the fields inside one entry
    localparam int ERR_BIT  = 0;
    localparam int ZERO_BIT = 1;
    localparam int NEG_BIT  = 2;
    localparam int DATA_LSB = 3;

    typedef enum logic {
        ST_NORMAL     = 1'b0,
        ST_OVERFLOWED = 1'b1
    } status_state_t;

    function automatic int entry_width(input int data_w);
        return data_w + FLAG_BITS;
    endfunction

endpackage

// File: rtl/mon_fifo.sv
// Generic synchronous first-word-fall-through FIFO. The head entry is read
// combinationally from the storage array, so it is visible on the cycle after
// it was written and the following entry is visible on the cycle after a pop.
// Pushes into a full FIFO without a same-cycle pop and pops from an empty
// FIFO are ignored.
module mon_fifo #(
    parameter int WIDTH = 35,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    // Storage array: written at the tail, contents need no reset
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally at DEPTH; occupancy follows push/pop
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/alu_result_monitor.sv
// Receiving end of the CPU result interface. Qualified samples of the ALU
// result and its N/Z flags are checked for flag consistency and buffered in a
// FWFT FIFO that drains over a valid/ready handshake. Samples arriving while
// the FIFO is full (and not popping) are dropped and flagged by a sticky
// overflow status; flag mismatches are counted in a saturating counter.
// Optional feature: define MON_CHANGE_ONLY_EN to qualify only samples that
// differ from the previously qualified one.
module alu_result_monitor
    import alu_mon_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = 8,
    parameter int ERR_W  = ERR_W_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    input  logic [DATA_W-1:0]      alu_result,
    input  logic                   NegativeFlag,
    input  logic                   ZeroFlag,
    input  logic                   out_ready,
    input  logic                   clr_status,
    output logic                   out_valid,
    output logic [DATA_W-1:0]      out_data,
    output logic                   out_neg,
    output logic                   out_zero,
    output logic                   out_flag_err,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   overflow,
    output logic [ERR_W-1:0]       err_count
);

    localparam int ENTRY_W = entry_width(DATA_W);
    localparam int CNT_W   = $clog2(DEPTH) + 1;

    logic               expected_z;
    logic               expected_n;
    logic               sample_err;
    logic               qualified;
    logic               pop;
    logic               push;
    logic               drop;
    logic [ENTRY_W-1:0] entry_in;
    logic [ENTRY_W-1:0] entry_head;
    logic [CNT_W-1:0]   fifo_count;
    logic               fifo_full;
    logic               fifo_empty;
    status_state_t      state;

    assign expected_z = (alu_result == '0);
    assign expected_n = alu_result[DATA_W-1];
    assign sample_err = (ZeroFlag != expected_z) | (NegativeFlag != expected_n);

`ifdef MON_CHANGE_ONLY_EN
    logic              have_last;
    logic [DATA_W+1:0] last_sample;
    logic [DATA_W+1:0] cur_sample;

    assign cur_sample = {alu_result, NegativeFlag, ZeroFlag};
    assign qualified  = in_valid & (~have_last | (cur_sample != last_sample));

    // Remember the last qualified sample, even when it ends up dropped
    always_ff @(posedge clk) begin
        if (!reset) begin
            have_last   <= 1'b0;
            last_sample <= '0;
        end else if (qualified) begin
            have_last   <= 1'b1;
            last_sample <= cur_sample;
        end
    end
`else
    assign qualified = in_valid;
`endif

    assign pop  = ~fifo_empty & out_ready;
    assign push = qualified & (~fifo_full | pop);
    assign drop = qualified & fifo_full & ~pop;

    // Pack one sample into the FIFO entry layout
    always_comb begin
        entry_in                       = '0;
        entry_in[DATA_LSB +: DATA_W]   = alu_result;
        entry_in[NEG_BIT]              = NegativeFlag;
        entry_in[ZERO_BIT]             = ZeroFlag;
        entry_in[ERR_BIT]              = sample_err;
    end

    mon_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (entry_in),
        .dout  (entry_head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Present the head entry; outputs read as zero while the FIFO is empty
    always_comb begin
        out_valid    = ~fifo_empty;
        out_data     = '0;
        out_neg      = 1'b0;
        out_zero     = 1'b0;
        out_flag_err = 1'b0;
        if (!fifo_empty) begin
            out_data     = entry_head[DATA_LSB +: DATA_W];
            out_neg      = entry_head[NEG_BIT];
            out_zero     = entry_head[ZERO_BIT];
            out_flag_err = entry_head[ERR_BIT];
        end
    end

    assign count    = fifo_count;
    assign full     = fifo_full;
    assign overflow = (state == ST_OVERFLOWED);

    // Overflow status: a drop always wins over a same-cycle clear
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_NORMAL;
        end else begin
            case (state)
                ST_NORMAL: begin
                    if (drop) begin
                        state <= ST_OVERFLOWED;
                    end
                end
                ST_OVERFLOWED: begin
                    if (clr_status && !drop) begin
                        state <= ST_NORMAL;
                    end
                end
                default: state <= ST_NORMAL;
            endcase
        end
    end

    // Saturating mismatch counter; a same-cycle error survives a clear
    always_ff @(posedge clk) begin
        if (!reset) begin
            err_count <= '0;
        end else if (clr_status) begin
            err_count <= (qualified && sample_err) ? ERR_W'(1) : '0;
        end else if (qualified && sample_err && (err_count != {ERR_W{1'b1}})) begin
            err_count <= err_count + ERR_W'(1);
        end
    end

endmodule
